// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the sequential radix-4 Booth multiplier.
//   mul_state_t   : controller states (IDLE, RUN, DONE)
//   booth_digit_t : recoded radix-4 digit {0, +1, +2, -1, -2}
//   iter_count()  : number of radix-4 iterations needed for a WIDTH-bit operand
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mul_state_t;

   typedef enum logic [2:0] {
      ZERO,
      POS1,
      POS2,
      NEG1,
      NEG2
   } booth_digit_t;

   // Operands are extended to WIDTH+2 bits so that an unsigned multiplier
   // with its MSB set still ends on a non-negative final digit.
   function automatic int unsigned iter_count(input int unsigned width);
      return (width + 2) / 2;
   endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// booth_pp_sel: combinational radix-4 Booth partial-product selector.
//   triple [2:0]           : multiplier bits {y+1, y, y-1}
//   mcand  [WIDTH+1:0]     : multiplicand, already extended to WIDTH+2 bits
//   pp     [2*WIDTH+3:0]   : digit * mcand, sign-extended to the accumulator width
module booth_pp_sel
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2:0]         triple,
   input  logic [WIDTH+1:0]   mcand,
   output logic [2*WIDTH+3:0] pp
);

   localparam int unsigned PW = 2 * WIDTH + 4;

   booth_digit_t   digit;
   logic [PW-1:0]  mcand_ext;
   logic [PW-1:0]  mag;

   always_comb begin
      digit = ZERO;
      case (triple)
         3'b001, 3'b010: digit = POS1;
         3'b011:         digit = POS2;
         3'b100:         digit = NEG2;
         3'b101, 3'b110: digit = NEG1;
         default:        digit = ZERO;
      endcase
   end

   assign mcand_ext = {{(PW - WIDTH - 2){mcand[WIDTH+1]}}, mcand};

   always_comb begin
      mag = '0;
      pp  = '0;
      case (digit)
         POS1, NEG1: mag = mcand_ext;
         POS2, NEG2: mag = {mcand_ext[PW-2:0], 1'b0};
         default:    mag = '0;
      endcase
      case (digit)
         NEG1, NEG2: pp = ~mag + PW'(1);
         default:    pp = mag;
      endcase
   end

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-4 Booth multiplier (MULT / MULTU).
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : request, accepted in IDLE or DONE when flush is low
//   is_signed    : 1 = two's complement operands, 0 = unsigned
//   src_a        : multiplicand
//   src_b        : multiplier (Booth-recoded two bits per cycle)
//   flush        : abort an in-flight operation; wins over start
//   busy         : high in RUN and DONE
//   done         : one-cycle pulse, hi/lo valid from this cycle
//   hi, lo       : upper / lower halves of the 2*WIDTH-bit product
module booth_mul_seq
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned ITER     = iter_count(WIDTH);
   localparam int unsigned CW       = $clog2(ITER);
   localparam int unsigned MW       = WIDTH + 2;
   localparam int unsigned AW       = 2 * WIDTH + 4;
   localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

   mul_state_t     state;
   mul_state_t     state_nxt;

   logic [CW-1:0]  cnt;
   logic [MW-1:0]  mcand;
   logic [MW:0]    mplier;
   logic [AW-1:0]  acc;
   logic [AW-1:0]  pp;
   logic [AW-1:0]  pp_shl;
   logic [AW-1:0]  acc_sum;
   logic [MW-1:0]  ext_a;
   logic [MW-1:0]  ext_b;

   logic           accept;
   logic           last_iter;
   logic           step;

   assign ext_a = is_signed ? {{2{src_a[WIDTH-1]}}, src_a} : {2'b00, src_a};
   assign ext_b = is_signed ? {{2{src_b[WIDTH-1]}}, src_b} : {2'b00, src_b};

   // Starts are ignored while RUN; in DONE a start chains straight into RUN.
   assign accept    = start && !flush && (state != RUN);
   assign last_iter = (cnt == LAST_CNT);
   assign step      = (state == RUN) && !flush;

   booth_pp_sel #(
      .WIDTH (WIDTH)
   ) u_pp_sel (
      .triple (mplier[2:0]),
      .mcand  (mcand),
      .pp     (pp)
   );

   // Partial products are weighted by 4^cnt rather than shifting the accumulator.
   assign pp_shl  = pp << {cnt, 1'b0};
   assign acc_sum = acc + pp_shl;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = RUN;
         end
         RUN: begin
            if (flush)          state_nxt = IDLE;
            else if (last_iter) state_nxt = DONE;
         end
         DONE: begin
            if (accept) state_nxt = RUN;
            else        state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         hi     <= '0;
         lo     <= '0;
      end else if (accept) begin
         cnt    <= '0;
         mcand  <= ext_a;
         mplier <= {ext_b, 1'b0};
         acc    <= '0;
      end else if (step) begin
         cnt    <= cnt + CW'(1);
         mplier <= {{2{mplier[MW]}}, mplier[MW:2]};
         acc    <= acc_sum;
         if (last_iter) begin
            hi <= acc_sum[2*WIDTH-1:WIDTH];
            lo <= acc_sum[WIDTH-1:0];
         end
      end
   end

   assign busy = (state == RUN) || (state == DONE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: scoreboard bench for booth_mul_seq. Stimulus pushes the
// expected {hi,lo} into a queue; a monitor pops and compares on every done.
module tb_booth_mul_seq;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          is_signed;
   logic          flush;
   logic [W-1:0]  src_a;
   logic [W-1:0]  src_b;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   int            t_issue  = 0;
   logic [63:0]   exp_q[$];

   booth_mul_seq #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_signed (is_signed),
      .src_a     (src_a),
      .src_b     (src_b),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) check("done_without_request", 64'(done), 64'd0);
         else                   check("product", {hi, lo}, exp_q.pop_front());
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input logic push, input logic [63:0] expv);
      src_a     = a;
      src_b     = b;
      is_signed = sgn;
      start     = 1'b1;
      if (push) exp_q.push_back(expv);
      t_issue   = cyc;
      @(posedge clk);
      #1 start  = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) check("done_timeout", 64'(done), 64'd1);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic [63:0] expv);
      int at;
      issue(a, b, sgn, 1'b1, expv);
      wait_done(40, at);
      if (at >= 0) check("latency", 64'(at - t_issue), 64'd18);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int          at1;
      int          at2;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic        rs;
      longint      sa;
      longint      sb;
      logic [63:0] model;

      rst_n     = 1'b0;
      start     = 1'b0;
      flush     = 1'b0;
      is_signed = 1'b0;
      src_a     = '0;
      src_b     = '0;
      #3;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed products
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
      run_op(32'd7,         32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000);
      run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000);
      run_op(32'h1234_5678, 32'd0,         1'b0, 64'd0);

      // Flush on the 5th RUN cycle, then restart immediately
      run_op(32'd5, 32'd6, 1'b0, 64'd30);
      issue(32'd9, 32'd9, 1'b0, 1'b0, 64'd0);
      repeat (4) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check("busy_before_flush", 64'(busy), 64'd1);
      @(posedge clk);
      #1 flush = 1'b0;
      check("busy_after_flush", 64'(busy), 64'd0);
      check("hilo_after_flush", {hi, lo}, 64'd30);
      issue(32'd3, 32'd4, 1'b0, 1'b1, 64'd12);
      check("busy_restart", 64'(busy), 64'd1);
      wait_done(40, at1);
      if (at1 >= 0) check("latency_restart", 64'(at1 - t_issue), 64'd18);
      @(posedge clk);
      #1;

      // start held through DONE -> back-to-back; operands changed mid-RUN
      src_a     = 32'd100;
      src_b     = 32'hFFFF_FFFE;
      is_signed = 1'b1;
      start     = 1'b1;
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FF38);
      t_issue   = cyc;
      @(posedge clk);
      #1;
      src_a     = 32'h0001_0000;
      src_b     = 32'h0001_0000;
      is_signed = 1'b0;
      exp_q.push_back(64'h0000_0001_0000_0000);
      wait_done(40, at1);
      if (at1 >= 0) check("latency_first", 64'(at1 - t_issue), 64'd18);
      @(posedge clk);
      #1 start = 1'b0;
      check("busy_chained", 64'(busy), 64'd1);
      wait_done(40, at2);
      if (at1 >= 0 && at2 >= 0) check("latency_b2b", 64'(at2 - at1), 64'd18);
      @(posedge clk);
      #1;

      // start and flush together in IDLE: not accepted
      src_a = 32'd11;
      src_b = 32'd13;
      start = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      flush = 1'b0;
      check("busy_start_flush", 64'(busy), 64'd0);
      repeat (20) @(posedge clk);
      #1 check("busy_idle_after", 64'(busy), 64'd0);

      // Asynchronous reset mid-RUN
      issue(32'h1234, 32'h5678, 1'b0, 1'b0, 64'd0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_done", 64'(done), 64'd0);
      check("async_rst_hilo", {hi, lo}, 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Random pairs against a 64-bit reference product
      for (int i = 0; i < 48; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         if (rs) begin
            sa    = longint'($signed(ra));
            sb    = longint'($signed(rb));
            model = 64'(sa * sb);
         end else begin
            model = {32'd0, ra} * {32'd0, rb};
         end
         run_op(ra, rb, rs, model);
      end

      repeat (3) @(posedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
